// File: rtl/varcic_mc_if.sv
// Configuration, sample-input and decimated-output bundle for the multi-channel CIC decimator.
// The master side feeds samples and settings; the slave side is the decimator itself.
interface varcic_mc_if #(
  parameter int CHANNELS  = 2,
  parameter int IN_WIDTH  = 18,
  parameter int OUT_WIDTH = 18
);
  logic [5:0]                    decimation;
  logic [5:0]                    out_shift;
  logic                          in_strobe;
  logic [CHANNELS*IN_WIDTH-1:0]  in_data;
  logic                          out_strobe;
  logic [CHANNELS*OUT_WIDTH-1:0] out_data;
  logic                          overflow;

  modport master (
    output decimation, out_shift, in_strobe, in_data,
    input  out_strobe, out_data, overflow
  );

  modport slave (
    input  decimation, out_shift, in_strobe, in_data,
    output out_strobe, out_data, overflow
  );
endinterface

// File: rtl/varcic_mc.sv
// Multi-channel CIC decimator with a runtime ratio (1..63) and a runtime output shift.
// Output scaling rounds half-up, then saturates; overflow is sticky until reset.
module varcic_mc #(
  parameter int STAGES    = 5,
  parameter int IN_WIDTH  = 18,
  parameter int OUT_WIDTH = 18,
  parameter int ACC_WIDTH = 48,
  parameter int CHANNELS  = 2
) (
  input logic        clock,
  input logic        reset,
  varcic_mc_if.slave bus
);
  localparam int SHIFT_MAX = ACC_WIDTH - OUT_WIDTH;
  localparam int SHIFT_LIM = (SHIFT_MAX > 63) ? 63 : SHIFT_MAX;
  localparam logic [5:0] SHIFT_CAP = 6'(SHIFT_LIM);
  localparam int FLUSH_W = $clog2(STAGES + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LEN = FLUSH_W'(STAGES);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  logic [5:0]         dec_eff;
  logic [5:0]         r_lat;
  logic [5:0]         cnt;
  logic [5:0]         s_cur;
  logic [5:0]         s_lat;
  logic               dec_change;
  logic               comb_strobe;
  logic [FLUSH_W-1:0] flush_cnt;
  logic               flush_done;

  logic signed [ACC_WIDTH-1:0] integ      [CHANNELS][STAGES];
  logic signed [ACC_WIDTH-1:0] integ_next [CHANNELS][STAGES];
  logic signed [ACC_WIDTH-1:0] comb_in    [CHANNELS][STAGES];
  logic signed [ACC_WIDTH-1:0] comb_diff  [CHANNELS][STAGES];
  logic signed [ACC_WIDTH-1:0] comb_dly   [CHANNELS][STAGES];
  logic signed [ACC_WIDTH-1:0] comb_out   [CHANNELS];

  logic signed [ACC_WIDTH:0]   rnd_add [CHANNELS];
  logic signed [ACC_WIDTH:0]   rnd_sum [CHANNELS];
  logic signed [ACC_WIDTH:0]   rnd_val [CHANNELS];
  logic signed [OUT_WIDTH-1:0] sat_val [CHANNELS];
  logic [CHANNELS-1:0]         sat_hit;

  logic                          out_strobe_r;
  logic [CHANNELS*OUT_WIDTH-1:0] out_data_r;
  logic                          overflow_r;

  assign dec_eff    = (bus.decimation == 6'd0) ? 6'd1 : bus.decimation;
  assign dec_change = (dec_eff != r_lat);
  assign s_cur      = (bus.out_shift > SHIFT_CAP) ? SHIFT_CAP : bus.out_shift;
  assign flush_done = (flush_cnt == FLUSH_LEN);

  assign bus.out_strobe = out_strobe_r;
  assign bus.out_data   = out_data_r;
  assign bus.overflow   = overflow_r;

  // Integrators cascade within one cycle so a ratio of 1 is a pure 2-cycle pass-through.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      integ_next[k][0] = integ[k][0] +
        {{(ACC_WIDTH - IN_WIDTH){bus.in_data[k*IN_WIDTH + IN_WIDTH - 1]}},
         bus.in_data[k*IN_WIDTH +: IN_WIDTH]};
      for (int i = 1; i < STAGES; i++) begin
        integ_next[k][i] = integ[k][i] + integ_next[k][i-1];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      for (int i = 0; i < STAGES; i++) begin
        comb_in[k][i]   = (i == 0) ? integ[k][STAGES-1] : comb_diff[k][i-1];
        comb_diff[k][i] = comb_in[k][i] - comb_dly[k][i];
      end
      comb_out[k] = comb_diff[k][STAGES-1];
    end
  end

  // Round half-up at the shift point, then clamp to the signed output range.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      rnd_add[k] = '0;
      if (s_lat != 6'd0) begin
        rnd_add[k][s_lat - 6'd1] = 1'b1;
      end
      rnd_sum[k] = {comb_out[k][ACC_WIDTH-1], comb_out[k]} + rnd_add[k];
      rnd_val[k] = rnd_sum[k] >>> s_lat;
      sat_hit[k] = 1'b0;
      if (rnd_val[k] > SAT_MAX) begin
        sat_val[k] = SAT_MAX[OUT_WIDTH-1:0];
        sat_hit[k] = 1'b1;
      end else if (rnd_val[k] < SAT_MIN) begin
        sat_val[k] = SAT_MIN[OUT_WIDTH-1:0];
        sat_hit[k] = 1'b1;
      end else begin
        sat_val[k] = rnd_val[k][OUT_WIDTH-1:0];
      end
    end
  end

  // A ratio change restarts the filter from a clean state, dropping any coincident sample.
  always_ff @(posedge clock) begin
    s_lat <= s_cur;
    if (reset) begin
      r_lat        <= dec_eff;
      cnt          <= 6'd0;
      comb_strobe  <= 1'b0;
      flush_cnt    <= '0;
      out_strobe_r <= 1'b0;
      out_data_r   <= '0;
      overflow_r   <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        for (int i = 0; i < STAGES; i++) begin
          integ[k][i]    <= '0;
          comb_dly[k][i] <= '0;
        end
      end
    end else if (dec_change) begin
      r_lat        <= dec_eff;
      cnt          <= 6'd0;
      comb_strobe  <= 1'b0;
      flush_cnt    <= '0;
      out_strobe_r <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        for (int i = 0; i < STAGES; i++) begin
          integ[k][i]    <= '0;
          comb_dly[k][i] <= '0;
        end
      end
    end else begin
      comb_strobe  <= 1'b0;
      out_strobe_r <= 1'b0;
      if (bus.in_strobe) begin
        for (int k = 0; k < CHANNELS; k++) begin
          for (int i = 0; i < STAGES; i++) begin
            integ[k][i] <= integ_next[k][i];
          end
        end
        if (cnt == r_lat - 6'd1) begin
          cnt         <= 6'd0;
          comb_strobe <= 1'b1;
        end else begin
          cnt <= cnt + 6'd1;
        end
      end
      if (comb_strobe) begin
        for (int k = 0; k < CHANNELS; k++) begin
          for (int i = 0; i < STAGES; i++) begin
            comb_dly[k][i] <= comb_in[k][i];
          end
        end
        if (!flush_done) begin
          flush_cnt <= flush_cnt + FLUSH_W'(1);
        end else begin
          out_strobe_r <= 1'b1;
          for (int k = 0; k < CHANNELS; k++) begin
            out_data_r[k*OUT_WIDTH +: OUT_WIDTH] <= sat_val[k];
          end
          if (|sat_hit) begin
            overflow_r <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_varcic_mc.sv
// Scoreboard bench for varcic_mc: stimulus pushes hand-computed results with their due cycle,
// and a negedge monitor pops and compares them whenever out_strobe is seen.
module tb_varcic_mc;
  localparam int STAGES    = 5;
  localparam int IN_WIDTH  = 18;
  localparam int OUT_WIDTH = 18;
  localparam int ACC_WIDTH = 48;
  localparam int CHANNELS  = 2;

  typedef struct {
    int cyc;
    int v0;
    int v1;
    bit chk;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   samp = 0;
  int   r_cur = 8;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  varcic_mc_if #(.CHANNELS(CHANNELS), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

  varcic_mc #(
    .STAGES(STAGES), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH),
    .ACC_WIDTH(ACC_WIDTH), .CHANNELS(CHANNELS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  task automatic checkOutput(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Results due at a decimation event are pushed once the flush of STAGES events is over.
  task automatic applyStimulus(input int d0, input int d1, input bit strobe,
                               input int e0, input int e1, input bit chk);
    @(posedge clock);
    #1;
    bus.in_strobe = strobe;
    bus.in_data   = {IN_WIDTH'(d1), IN_WIDTH'(d0)};
    if (strobe) begin
      if ((samp % r_cur) == (r_cur - 1) && (samp / r_cur) >= STAGES) begin
        sb.push_back('{cyc: cyc + 2, v0: e0, v1: e1, chk: chk});
      end
      samp++;
    end
  endtask

  task automatic runDc(input int d0, input int d1, input int e0, input int e1,
                       input int n, input int gap, input bit chk);
    for (int j = 0; j < n; j++) begin
      applyStimulus(d0, d1, 1'b1, e0, e1, chk);
      repeat (gap - 1) applyStimulus(d0, d1, 1'b0, 0, 0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic doReset(input int dec, input int shift);
    @(posedge clock);
    #1;
    reset          = 1'b1;
    bus.in_strobe  = 1'b0;
    bus.decimation = 6'(dec);
    bus.out_shift  = 6'(shift);
    r_cur          = (dec == 0) ? 1 : dec;
    @(posedge clock);
    #1;
    reset = 1'b0;
    samp  = 0;
    checkOutput("rst_out_strobe", longint'(bus.out_strobe), 0);
    checkOutput("rst_out_ch0", $signed(bus.out_data[0 +: OUT_WIDTH]), 0);
    checkOutput("rst_out_ch1", $signed(bus.out_data[OUT_WIDTH +: OUT_WIDTH]), 0);
    checkOutput("rst_overflow", longint'(bus.overflow), 0);
  endtask

  task automatic setDecimation(input int dec);
    @(posedge clock);
    #1;
    bus.in_strobe  = 1'b0;
    bus.decimation = 6'(dec);
    r_cur          = (dec == 0) ? 1 : dec;
    samp           = 0;
  endtask

  always @(negedge clock) begin
    if (reset === 1'b0 && bus.out_strobe === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_out_strobe: strobe at cycle %0d, required none", cyc);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("out_cycle", cyc, mon_e.cyc);
        if (mon_e.chk) begin
          checkOutput("out_ch0", $signed(bus.out_data[0 +: OUT_WIDTH]), mon_e.v0);
          checkOutput("out_ch1", $signed(bus.out_data[OUT_WIDTH +: OUT_WIDTH]), mon_e.v1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    bus.in_strobe  = 1'b0;
    bus.in_data    = '0;
    bus.decimation = 6'd8;
    bus.out_shift  = 6'd15;

    // DC unity gain: 8^5 = 2^15, so a shift of 15 returns the input exactly.
    doReset(8, 15);
    runDc(1000, -1000, 1000, -1000, 80, 4, 1'b1);
    idle(4);
    checkOutput("dc_hold_ch0", $signed(bus.out_data[0 +: OUT_WIDTH]), 1000);
    checkOutput("dc_overflow", longint'(bus.overflow), 0);
    checkOutput("dc_drained", sb.size(), 0);

    // Pass-through at R=1 and R=0: output is the input two cycles later.
    for (int pass = 0; pass < 2; pass++) begin
      doReset((pass == 0) ? 1 : 0, 0);
      for (int t = 0; t < 20; t++) begin
        applyStimulus(t, -3 * t, 1'b1, t, -3 * t, 1'b1);
      end
      idle(4);
      checkOutput("pass_drained", sb.size(), 0);
    end

    // Rounding: gain 32, (96+32)>>>6 = 2 and (-96+32)>>>6 = -1.
    doReset(2, 6);
    runDc(3, -3, 2, -1, 16, 1, 1'b1);
    idle(4);
    checkOutput("round_drained", sb.size(), 0);

    // Saturation at both rails, then overflow must stay set with zero input.
    doReset(8, 14);
    runDc(131071, -131072, 131071, -131072, 64, 1, 1'b1);
    idle(4);
    checkOutput("sat_overflow", longint'(bus.overflow), 1);
    runDc(0, 0, 0, 0, 40, 1, 1'b0);
    runDc(0, 0, 0, 0, 40, 1, 1'b1);
    idle(4);
    checkOutput("sat_overflow_sticky", longint'(bus.overflow), 1);
    checkOutput("sat_drained", sb.size(), 0);

    // Ratio change 8 -> 4 mid-frame: gain drops from 32768/1024 to 1024/1024.
    doReset(8, 10);
    runDc(1000, 500, 32000, 16000, 56, 2, 1'b1);
    runDc(1000, 500, 0, 0, 3, 2, 1'b1);
    idle(2);
    setDecimation(4);
    runDc(1000, 500, 1000, 500, 20, 2, 1'b1);
    checkOutput("flush_hold_ch0", $signed(bus.out_data[0 +: OUT_WIDTH]), 32000);
    runDc(1000, 500, 1000, 500, 12, 2, 1'b1);
    idle(4);
    checkOutput("dec_overflow", longint'(bus.overflow), 0);
    checkOutput("dec_drained", sb.size(), 0);

    // Reset in the middle of a frame discards it and restarts the flush.
    doReset(8, 15);
    runDc(1000, -1000, 1000, -1000, 72, 2, 1'b1);
    runDc(1000, -1000, 0, 0, 3, 2, 1'b1);
    idle(2);
    checkOutput("pre_reset_drained", sb.size(), 0);
    doReset(8, 15);
    runDc(1000, -1000, 1000, -1000, 56, 2, 1'b1);
    idle(4);
    checkOutput("post_reset_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/varcic_mc.md
# varcic_mc

Multi-channel, runtime-programmable CIC decimator that succeeds the single-channel variable CIC in the receiver DDC chain. It decimates CHANNELS parallel input streams that share one input strobe by any integer ratio from 1 to 63. Output scaling is a runtime arithmetic shift with round-half-up and saturation, plus a sticky overflow flag. It sits between the CORDIC/mixer outputs and the FIR decimator, replacing per-rate hard-coded rounding with a software-supplied shift.

## Interface
- STAGES, 5, number of integrator/comb pairs (1..8)
- IN_WIDTH, 18, signed input sample width per channel
- OUT_WIDTH, 18, signed output sample width per channel
- ACC_WIDTH, 48, accumulator width; must be ≥ IN_WIDTH + ceil(STAGES·log2(63))
- CHANNELS, 2, number of parallel channels (1..8)
- clock  input  1  sole clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- decimation  input  6  decimation ratio R; 0 is treated as 1
- out_shift  input  6  right-shift applied to the comb result; values above ACC_WIDTH-OUT_WIDTH are clamped to ACC_WIDTH-OUT_WIDTH
- in_strobe  input  1  one-cycle qualifier for in_data
- in_data  input  CHANNELS·IN_WIDTH  packed signed samples; channel k occupies bits [k·IN_WIDTH +: IN_WIDTH]
- out_strobe  output  1  one-cycle pulse marking a new out_data
- out_data  output  CHANNELS·OUT_WIDTH  packed signed results, same packing as in_data; held between strobes
- overflow  output  1  sticky; set when any channel saturates

## Operation
- Integrators: on in_strobe, stage 0 accumulates the sign-extended in_data, and stage i accumulates the output of stage i-1. Arithmetic wraps modulo 2^ACC_WIDTH; wrap is intentional.
- Counter: a sample counter increments on in_strobe. When the counter equals R-1 on an in_strobe, it returns to 0 and comb_strobe is registered high for one cycle.
- Combs: each stage outputs its input minus its delay register (combinational, ACC_WIDTH wide). On comb_strobe, each delay register loads that stage's input. Differential delay is 1.
- Output: on comb_strobe, compute r = (c + 2^(s-1)) >>> s, where c is the final comb output and s is the clamped out_shift. When s = 0, r = c.
- Saturation: saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and register it into out_data. On saturation, set overflow.
- Configuration latch: R and s are latched into internal registers. out_shift may change at any time and takes effect on the next output.
- Decimation change: when the live decimation value differs from the latched R, the block does the following in the same cycle:
  - latches the new R;
  - clears the counter, integrators, comb delays and flush counter;
  - ignores any coincident in_strobe.
- Flush: after reset or a decimation change, the first STAGES comb_strobe events still update the comb delays but do not assert out_strobe. out_data keeps its previous value during this time.
- Channels: all channels share the counter, strobes, R and s. Channels are otherwise fully independent.

## Timing
- Reset values:
  - out_strobe = 0, out_data = 0, overflow = 0;
  - counter, integrators, comb delays and flush counter = 0;
  - latched R = current decimation, with 0 mapped to 1.
- Reset has priority over in_strobe and over decimation change. Reset asserted mid-decimation discards the partial output.
- Latency: an in_strobe at cycle t that completes a decimation count gives comb_strobe at t+1 and out_strobe/out_data at t+2.
- in_strobe may be asserted every cycle, including at R = 1. In that case one output is produced per input, 2 cycles later.
- Counter wrap: the counter never exceeds R-1. A live R change is handled by the decimation-change rule, never by comparing against a stale count.
- overflow clears only on reset.

## Test plan
- **DC unity gain:** CHANNELS=2, R=8, s=15, ch0 = +1000 and ch1 = -1000 on every in_strobe, strobe every 4 cycles.
  - Required: no out_strobe for the first 5 decimated events.
  - Required: after settling, ch0 = +1000 and ch1 = -1000 exactly; overflow stays 0.
- **Pass-through and latency:** R=1 (and separately R=0), s=0, strobe every cycle, ramp input 0,1,2…
  - Required: after the 5-output flush, out_data equals the input delayed by 2 cycles.
- **Rounding:** R=2, s=6, DC input 3.
  - Required: 3·32 = 96; (96+32)>>>6 = 2, so settled output = 2.
  - Required: input -3 gives settled output -1.
- **Saturation:** R=8, s=14, DC input 131071.
  - Required: output = 131071 and overflow = 1.
  - Required: overflow stays 1 after the input returns to 0, until reset.
- **Decimation change:** switch R from 8 to 4 mid-frame.
  - Required: no out_strobe for the next 5 decimated events.
  - Required: out_strobe spacing then equals 4 input strobes, and DC 1000 with s=10 settles to 1000.
- **Reset mid-operation:** assert reset for one cycle between strobes.
  - Required: all outputs return to 0 the next cycle.
  - Required: the flush restarts, and the first out_strobe comes 5 full decimation periods later.
